// File: rtl/cpu_types_pkg.sv
// ----------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU datapath types: machine word, register-select width and the
// number of register-file writeback requesters.
// ----------------------------------------------------------------------------
package cpu_types_pkg;

   localparam int unsigned WORD_W  = 32;
   localparam int unsigned REGSEL_W = 5;
   localparam int unsigned NREQ    = 2;

   typedef logic [WORD_W-1:0]   word_t;
   typedef logic [REGSEL_W-1:0] regbits_t;

endpackage : cpu_types_pkg

// File: rtl/wb_slot.sv
// ----------------------------------------------------------------------------
// wb_slot
// One writeback buffer entry: holds a destination select, a data word, a
// full flag and an age bit (1 = this entry is older than the other one).
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   load                 capture load_wsel/load_wdat, mark full, mark young
//   clear                entry drained this cycle (ignored when load is high)
//   set_old              other entry was loaded while this one stays full
//   load_wsel, load_wdat incoming write
//   full, age            entry state
//   wsel, wdat           buffered write
// ----------------------------------------------------------------------------
module wb_slot
   import cpu_types_pkg::*;
(
   input  logic     clk,
   input  logic     rst,
   input  logic     load,
   input  logic     clear,
   input  logic     set_old,
   input  regbits_t load_wsel,
   input  word_t    load_wdat,
   output logic     full,
   output logic     age,
   output regbits_t wsel,
   output word_t    wdat
);

   // Load wins over clear so a drained entry can be refilled in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         full <= 1'b0;
         age  <= 1'b0;
         wsel <= '0;
         wdat <= '0;
      end else if (load) begin
         full <= 1'b1;
         age  <= 1'b0;
         wsel <= load_wsel;
         wdat <= load_wdat;
      end else if (clear) begin
         full <= 1'b0;
         age  <= 1'b0;
      end else if (set_old) begin
         age  <= 1'b1;
      end
   end

endmodule : wb_slot

// File: rtl/regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// regfile_wb_arbiter
// Buffers one register-file write per requester and drains one buffered
// write per cycle onto the register-file write port. Older entries win;
// simultaneous loads are broken by a round-robin pointer. Also flags decode
// read selects that name a still-pending write.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/wsel/wdat       per-requester write offer
//   req_ready                 per-requester accept (empty or draining now)
//   rf_wen/rf_wsel/rf_wdat    register-file write port (combinational)
//   rsel_1, rsel_2            decode read selects
//   hazard_1, hazard_2        read select matches a pending non-r0 write
//   busy                      at least one buffer entry is full
// Only NREQ = 2 is supported.
// ----------------------------------------------------------------------------
module regfile_wb_arbiter
   import cpu_types_pkg::*;
#(
   parameter int unsigned NREQ = cpu_types_pkg::NREQ
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [NREQ-1:0] req_valid,
   input  regbits_t        req_wsel [NREQ],
   input  word_t           req_wdat [NREQ],
   output logic [NREQ-1:0] req_ready,
   output logic            rf_wen,
   output regbits_t        rf_wsel,
   output word_t           rf_wdat,
   input  regbits_t        rsel_1,
   input  regbits_t        rsel_2,
   output logic            hazard_1,
   output logic            hazard_2,
   output logic            busy
);

   logic [NREQ-1:0] full;
   logic [NREQ-1:0] age;
   logic [NREQ-1:0] grant;
   logic [NREQ-1:0] load;
   logic [NREQ-1:0] set_old;
   regbits_t        slot_wsel [NREQ];
   word_t           slot_wdat [NREQ];
   logic            tie;
   logic            rr_ptr;

   // Buffer entries
   for (genvar i = 0; i < NREQ; i++) begin : g_slot
      wb_slot u_slot (
         .clk       (clk),
         .rst       (rst),
         .load      (load[i]),
         .clear     (grant[i]),
         .set_old   (set_old[i]),
         .load_wsel (req_wsel[i]),
         .load_wdat (req_wdat[i]),
         .full      (full[i]),
         .age       (age[i]),
         .wsel      (slot_wsel[i]),
         .wdat      (slot_wdat[i])
      );
   end

   // Grant: lone full entry, else the older one, else the round-robin pointer
   always_comb begin
      grant = '0;
      tie   = 1'b0;
      if (full[0] && !full[1]) begin
         grant[0] = 1'b1;
      end else if (full[1] && !full[0]) begin
         grant[1] = 1'b1;
      end else if (full[0] && full[1]) begin
         if (age[0] && !age[1]) begin
            grant[0] = 1'b1;
         end else if (age[1] && !age[0]) begin
            grant[1] = 1'b1;
         end else begin
            tie           = 1'b1;
            grant[rr_ptr] = 1'b1;
         end
      end
   end

   // Handshake, and ageing of an entry that stays full while the other loads
   always_comb begin
      req_ready = ~full | grant;
      load      = req_valid & req_ready;
      set_old   = '0;
      for (int i = 0; i < NREQ; i++) begin
         for (int j = 0; j < NREQ; j++) begin
            if (j != i && load[j] && full[i] && !grant[i]) begin
               set_old[i] = 1'b1;
            end
         end
      end
   end

   // Write port mux; writes to r0 are drained silently
   always_comb begin
      rf_wsel = '0;
      rf_wdat = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            rf_wsel = slot_wsel[i];
            rf_wdat = slot_wdat[i];
         end
      end
      rf_wen = (|grant) && (rf_wsel != '0);
   end

   // Hazards include the entry being granted this cycle
   always_comb begin
      hazard_1 = 1'b0;
      hazard_2 = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (full[i] && slot_wsel[i] != '0) begin
            if (slot_wsel[i] == rsel_1) hazard_1 = 1'b1;
            if (slot_wsel[i] == rsel_2) hazard_2 = 1'b1;
         end
      end
      busy = |full;
   end

   // Round-robin pointer moves only after a tie is resolved
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= 1'b0;
      end else if (tie) begin
         rr_ptr <= ~rr_ptr;
      end
   end

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// ----------------------------------------------------------------------------
// tb_regfile_wb_arbiter
// Self-checking bench: expected register-file writes (cycle, select, data)
// are queued when stimulus is driven and compared when rf_wen fires.
// ----------------------------------------------------------------------------
module tb_regfile_wb_arbiter;
   import cpu_types_pkg::*;

   typedef struct {
      int unsigned cyc;
      regbits_t    wsel;
      word_t       wdat;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NREQ-1:0] req_valid = '0;
   regbits_t        req_wsel [NREQ];
   word_t           req_wdat [NREQ];
   logic [NREQ-1:0] req_ready;
   logic            rf_wen;
   regbits_t        rf_wsel;
   word_t           rf_wdat;
   regbits_t        rsel_1 = '0;
   regbits_t        rsel_2 = '0;
   logic            hazard_1;
   logic            hazard_2;
   logic            busy;

   int unsigned cyc = 0;
   int          n_checks = 0;
   int          n_pass = 0;
   logic        mon_en = 1'b0;
   exp_t        sb [$];
   word_t       tb_rf [32];

   regfile_wb_arbiter #(.NREQ(NREQ)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_wsel  (req_wsel),
      .req_wdat  (req_wdat),
      .req_ready (req_ready),
      .rf_wen    (rf_wen),
      .rf_wsel   (rf_wsel),
      .rf_wdat   (rf_wdat),
      .rsel_1    (rsel_1),
      .rsel_2    (rsel_2),
      .hazard_1  (hazard_1),
      .hazard_2  (hazard_2),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Register-file image built from the write port
   always @(posedge clk) if (mon_en && rf_wen) tb_rf[rf_wsel] <= rf_wdat;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   task automatic expect_wr(input int unsigned c, input regbits_t s, input word_t d);
      exp_t e;
      e.cyc  = c;
      e.wsel = s;
      e.wdat = d;
      sb.push_back(e);
   endtask

   // Drive one cycle of offers, then return #2 after the capturing edge
   task automatic drive(input logic [1:0] v, input regbits_t s0, input word_t d0,
                        input regbits_t s1, input word_t d1);
      req_valid   = v;
      req_wsel[0] = s0;
      req_wdat[0] = d0;
      req_wsel[1] = s1;
      req_wdat[1] = d1;
      @(posedge clk);
      #1;
      req_valid = '0;
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // Scoreboard: every write pulse must match the head of the queue
   always @(negedge clk) begin
      if (mon_en && rf_wen) begin
         if (sb.size() == 0) begin
            check("unexpected_write", {27'd0, rf_wsel, rf_wdat}, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("wr_cycle", 64'(cyc), 64'(e.cyc));
            check("wr_wsel", 64'(rf_wsel), 64'(e.wsel));
            check("wr_wdat", 64'(rf_wdat), 64'(e.wdat));
         end
      end
   end

   initial begin
      int unsigned b;
      req_wsel[0] = '0; req_wsel[1] = '0;
      req_wdat[0] = '0; req_wdat[1] = '0;

      // Reset
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      #1;
      mon_en = 1'b1;
      check("rst_rf_wen", 64'(rf_wen), 64'd0);
      check("rst_rf_wsel", 64'(rf_wsel), 64'd0);
      check("rst_rf_wdat", 64'(rf_wdat), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_hazards", 64'({hazard_1, hazard_2}), 64'd0);
      check("rst_ready", 64'(req_ready), 64'd3);

      // Solo write: visible exactly one cycle after acceptance
      rsel_1 = 5'd5;
      expect_wr(cyc + 1, 5'd5, 32'hDEADBEEF);
      drive(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0);
      check("solo_wen", 64'(rf_wen), 64'd1);
      check("solo_busy", 64'(busy), 64'd1);
      check("solo_hazard_granted", 64'(hazard_1), 64'd1);
      idle(1);
      check("solo_busy_after", 64'(busy), 64'd0);
      check("solo_hazard_after", 64'(hazard_1), 64'd0);

      // Tie from reset pointer: req0 first, then pointer favours req1
      b = cyc;
      expect_wr(b + 1, 5'd3, 32'h11);
      expect_wr(b + 2, 5'd3, 32'h22);
      drive(2'b11, 5'd3, 32'h11, 5'd3, 32'h22);
      check("tie_ready", 64'(req_ready), 64'd1);
      idle(2);
      check("tie_busy_after", 64'(busy), 64'd0);
      b = cyc;
      expect_wr(b + 1, 5'd3, 32'h44);
      expect_wr(b + 2, 5'd3, 32'h33);
      drive(2'b11, 5'd3, 32'h33, 5'd3, 32'h44);
      idle(2);
      check("tie2_busy_after", 64'(busy), 64'd0);

      // Age beats pointer: after the third cycle req0 is older while ptr=1
      b = cyc;
      expect_wr(b + 1, 5'd3, 32'hA0);
      expect_wr(b + 2, 5'd3, 32'hB0);
      expect_wr(b + 3, 5'd3, 32'hC0);
      expect_wr(b + 4, 5'd3, 32'hD0);
      drive(2'b11, 5'd3, 32'hA0, 5'd3, 32'hB0);
      drive(2'b01, 5'd3, 32'hC0, 5'd0, 32'd0);
      drive(2'b10, 5'd0, 32'd0, 5'd3, 32'hD0);
      check("age_both_full", 64'(busy), 64'd1);
      idle(3);
      check("age_final_r3", 64'(tb_rf[3]), 64'hD0);
      check("age_busy_after", 64'(busy), 64'd0);

      // Register 0: drained silently, never a hazard
      rsel_1 = 5'd0;
      drive(2'b01, 5'd0, 32'h1234, 5'd0, 32'd0);
      check("zero_wen", 64'(rf_wen), 64'd0);
      check("zero_busy", 64'(busy), 64'd1);
      check("zero_hazard", 64'(hazard_1), 64'd0);
      idle(1);
      check("zero_busy_after", 64'(busy), 64'd0);

      // Pending r7 flagged, then discarded by reset (pointer is 1 here)
      rsel_2 = 5'd7;
      expect_wr(cyc + 1, 5'd2, 32'hBEEF);
      drive(2'b11, 5'd7, 32'h7777, 5'd2, 32'hBEEF);
      check("hz_hazard2", 64'(hazard_2), 64'd1);
      check("hz_wsel", 64'(rf_wsel), 64'd2);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("hzrst_wen", 64'(rf_wen), 64'd0);
      check("hzrst_hazard2", 64'(hazard_2), 64'd0);
      check("hzrst_ready", 64'(req_ready), 64'd3);
      check("hzrst_busy", 64'(busy), 64'd0);

      // Pointer cleared by reset: tie goes to req0 again
      b = cyc;
      expect_wr(b + 1, 5'd3, 32'h55);
      expect_wr(b + 2, 5'd3, 32'h66);
      drive(2'b11, 5'd3, 32'h55, 5'd3, 32'h66);
      idle(3);

      check("sb_drained", 64'(sb.size()), 64'd0);
      check("final_busy", 64'(busy), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_regfile_wb_arbiter
